// File: rtl/cpu_mem_interface.sv
`timescale 1ns/1ps
// cpu_mem_interface
//   Bridges a multicycle CPU's control-unit strobes to a handshaked external
//   memory. An access is launched from IDLE, and its address, write data and
//   direction are captured at launch. It runs in BUSY until mem_ack arrives
//   or the TIMEOUT bound runs out, and it finishes with one DONE cycle. Read
//   data lands in the IR or the MDR, depending on the captured ir_write.
//
// Ports
//   clk, reset                 : clock, synchronous active-high reset
//   mem_read, mem_write        : access strobes from the control unit
//   ir_write, iord             : read destination (IR vs MDR), address select
//   pc, alu_out, b_data        : address sources and store data
//   mem_addr, mem_wdata        : latched address / write data to memory
//   mem_req, mem_we            : request (BUSY only) and write enable
//   mem_ack, mem_rdata         : memory completion and read data
//   ir, mdr                    : instruction / memory data registers
//   stall                      : holds the control unit while an access is open
//   err                        : one-cycle pulse in DONE for an illegal or timed-out access
module cpu_mem_interface #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        ir_write,
  input  logic        iord,
  input  logic [31:0] pc,
  input  logic [31:0] alu_out,
  input  logic [31:0] b_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ir,
  output logic [31:0] mdr,
  output logic        stall,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        irw_q, irw_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] mdr_q, mdr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  logic        access_req;
  logic [31:0] addr_sel;
  logic [7:0]  cnt_inc;

  assign access_req = mem_read | mem_write;
  assign addr_sel   = iord ? alu_out : pc;
  assign cnt_inc    = cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    irw_d   = irw_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (access_req) begin
          addr_d  = addr_sel;
          wdata_d = b_data;
          we_d    = mem_write;
          irw_d   = ir_write;
          cnt_d   = 8'd0;
          // Illegal accesses never reach the bus; they go straight to DONE
          // so the err pulse and the stall release keep the usual timing.
          if ((mem_read & mem_write) || (addr_sel[1:0] != 2'b00)) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_inc;
        // When the ack arrives in the last allowed cycle, the ack takes priority over the timeout.
        if (mem_ack) begin
          if (!we_q) begin
            if (irw_q) ir_d  = mem_rdata;
            else       mdr_d = mem_rdata;
          end
          state_d = DONE;
        end else if (cnt_inc == TO) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      // DONE always returns to IDLE, so strobes that are still held cannot relaunch the access here.
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      irw_q   <= 1'b0;
      ir_q    <= '0;
      mdr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      irw_q   <= irw_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_req   = (state_q == BUSY);
  assign mem_we    = (state_q == BUSY) & we_q;
  assign ir        = ir_q;
  assign mdr       = mdr_q;
  assign err       = err_q;
  assign stall     = ((state_q == IDLE) & access_req) | (state_q == BUSY);

endmodule

// File: tb/tb_cpu_mem_interface.sv
`timescale 1ns/1ps
module tb_cpu_mem_interface;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write, ir_write, iord;
  logic [31:0] pc, alu_out, b_data;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_req, mem_we;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] ir, mdr;
  logic        stall, err;

  always #5 clk = ~clk;

  cpu_mem_interface #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .iord(iord),
    .pc(pc), .alu_out(alu_out), .b_data(b_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir(ir), .mdr(mdr), .stall(stall), .err(err)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          req_n;
    int          stall_n;
    int          err_n;
    logic [31:0] ir;
    logic [31:0] mdr;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(logic [31:0] a, logic w, logic [31:0] wd, int rq, int st,
                              int e, logic [31:0] i, logic [31:0] m);
    exp_t x;
    x.addr = a; x.we = w; x.wdata = wd; x.req_n = rq; x.stall_n = st;
    x.err_n = e; x.ir = i; x.mdr = m;
    return x;
  endfunction

  // Monitor: bus checks on every request cycle, completion checks on the
  // cycle stall drops after an open access.
  int   req_n = 0, stall_n = 0, err_n = 0;
  logic prev_stall = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
      req_n = 0; stall_n = 0; err_n = 0; prev_stall = 1'b0;
    end else begin
      if (mem_req) begin
        req_n++;
        if (sb_q.size() == 0) chk("unexpected_mem_req", 32'(mem_req), 32'd0);
        else begin
          chk("mem_addr", mem_addr, sb_q[0].addr);
          chk("mem_we", 32'(mem_we), 32'(sb_q[0].we));
          if (sb_q[0].we) chk("mem_wdata", mem_wdata, sb_q[0].wdata);
        end
      end
      if (stall) stall_n++;
      if (err) err_n++;
      if (prev_stall && !stall) begin
        if (sb_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("req_cycles",   32'(req_n),   32'(e.req_n));
          chk("stall_cycles", 32'(stall_n), 32'(e.stall_n));
          chk("err_pulses",   32'(err_n),   32'(e.err_n));
          chk("ir",  ir,  e.ir);
          chk("mdr", mdr, e.mdr);
        end
        req_n = 0; stall_n = 0; err_n = 0;
      end
      prev_stall = stall;
    end
  end

  // Driver: ack_at is the BUSY cycle (1-based) carrying mem_ack, 0 = never.
  // Strobes stay up through DONE and drop just after DONE->IDLE.
  task automatic access(input logic rd, input logic wr, input logic irw, input logic io,
                        input logic [31:0] pcv, input logic [31:0] aluv, input logic [31:0] bv,
                        input int ack_at, input logic [31:0] rdata, input exp_t e);
    int  n;
    bit  done;
    sb_q.push_back(e);
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; ir_write = irw; iord = io;
    pc = pcv; alu_out = aluv; b_data = bv; mem_ack = 1'b0;
    n = 0; done = 0;
    while (!done && n < 50) begin
      @(posedge clk); #1;
      n++;
      if (!stall) done = 1;
      else begin
        mem_ack   = (n == ack_at);
        mem_rdata = (n == ack_at) ? rdata : 32'hA5A5A5A5;
      end
    end
    if (!done) chk("access_completion_bound", 32'd0, 32'd1);
    mem_ack = 1'b0;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0; ir_write = 1'b0; iord = 1'b0;
    mem_rdata = 32'h5A5A5A5A;
  endtask

  initial begin
    reset = 1'b1;
    mem_read = 0; mem_write = 0; ir_write = 0; iord = 0;
    pc = 0; alu_out = 0; b_data = 0; mem_ack = 0; mem_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we",  32'(mem_we),  32'd0);
    chk("rst_err",     32'(err),     32'd0);
    chk("rst_ir",      ir,           32'd0);
    chk("rst_mdr",     mdr,          32'd0);
    chk("rst_stall_idle", 32'(stall), 32'd0);
    mem_read = 1'b1; #1;
    chk("rst_stall_req", 32'(stall), 32'd1);
    mem_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    // fetch: ack in 2nd BUSY cycle
    access(1,0,1,0, 32'h40, 32'h200, 32'h0, 2, 32'h8C220004,
           mk(32'h40, 0, 32'h0, 2, 3, 0, 32'h8C220004, 32'h0));
    // load: ack in 1st BUSY cycle
    access(1,0,0,1, 32'h44, 32'h100, 32'h0, 1, 32'hDEADBEEF,
           mk(32'h100, 0, 32'h0, 1, 2, 0, 32'h8C220004, 32'hDEADBEEF));
    // store: rdata on the ack must be ignored
    access(0,1,0,1, 32'h48, 32'h104, 32'h12345678, 1, 32'hFFFFFFFF,
           mk(32'h104, 1, 32'h12345678, 1, 2, 0, 32'h8C220004, 32'hDEADBEEF));
    // misaligned ALU address
    access(1,0,0,1, 32'h48, 32'h102, 32'h0, 1, 32'h77777777,
           mk(32'h0, 0, 32'h0, 0, 1, 1, 32'h8C220004, 32'hDEADBEEF));
    // read and write together
    access(1,1,0,1, 32'h48, 32'h108, 32'h9, 1, 32'h66666666,
           mk(32'h0, 0, 32'h0, 0, 1, 1, 32'h8C220004, 32'hDEADBEEF));
    // timeout (TIMEOUT=4), no ack
    access(1,0,1,0, 32'h48, 32'h0, 32'h0, 0, 32'h0,
           mk(32'h48, 0, 32'h0, 4, 5, 1, 32'h8C220004, 32'hDEADBEEF));
    // ack in the same cycle as the timeout wins
    access(1,0,0,0, 32'h4C, 32'h0, 32'h0, 4, 32'hCAFEF00D,
           mk(32'h4C, 0, 32'h0, 4, 5, 0, 32'h8C220004, 32'hCAFEF00D));
    // misaligned PC fetch
    access(1,0,1,0, 32'h41, 32'h0, 32'h0, 1, 32'h55555555,
           mk(32'h0, 0, 32'h0, 0, 1, 1, 32'h8C220004, 32'hCAFEF00D));

    // reset in BUSY with a late ack
    @(posedge clk); #1;
    mem_read = 1'b1; ir_write = 1'b1; iord = 1'b0; pc = 32'h50;
    @(posedge clk); #1;
    chk("busy_mem_req", 32'(mem_req), 32'd1);
    chk("busy_mem_addr", mem_addr, 32'h50);
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h11111111;
    mem_read = 1'b0; ir_write = 1'b0;
    @(posedge clk); #1;
    chk("rstbusy_mem_req", 32'(mem_req), 32'd0);
    chk("rstbusy_stall",   32'(stall),   32'd0);
    chk("rstbusy_err",     32'(err),     32'd0);
    chk("rstbusy_ir",      ir,           32'd0);
    chk("rstbusy_mdr",     mdr,          32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("lateack_mem_req", 32'(mem_req), 32'd0);
    chk("lateack_ir",      ir,           32'd0);
    chk("lateack_mdr",     mdr,          32'd0);
    mem_ack = 1'b0;

    // fetch after reset
    access(1,0,1,0, 32'h60, 32'h0, 32'h0, 1, 32'h20080001,
           mk(32'h60, 0, 32'h0, 1, 2, 0, 32'h20080001, 32'h0));

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained",    32'(sb_q.size()), 32'd0);
    chk("trailing_err",  32'(err_n),       32'd0);
    chk("trailing_req",  32'(req_n),       32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
